// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder slice (package Pipe_Buf_Reg_PKG).
//   dmem_state_t : responder FSM states (IDLE, WAIT, RESP)
//   F3_*         : RISC-V funct3 load/store size and sign encodings
//   f3_legal()   : 1 when funct3 names a supported access for the given direction
package Pipe_Buf_Reg_PKG;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        if (we) begin
            ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end else begin
            ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for the data-memory responder.
// Extracts and sign/zero-extends load data from a 32-bit memory word and merges
// store data into the addressed byte lanes.
// Config macro: DMEM_MISALIGN_ERR_EN -- when defined, misaligned halfword/word
// accesses are rejected; otherwise the low address bits are forced to alignment.
// Ports:
//   we        in   1  1 = store, 0 = load
//   func3     in   3  RISC-V funct3 size/sign
//   addr_lo   in   2  byte offset within the word
//   wdata     in  32  store data, right-aligned
//   mem_word  in  32  current contents of the addressed word
//   load_data out 32  extended load result (0 for stores and errors)
//   wr_word   out 32  merged word to write back
//   wr_en     out  1  write the merged word
//   err       out  1  access rejected
module dmem_lane_align
    import Pipe_Buf_Reg_PKG::*;
(
    input  logic        we,
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_word,
    output logic [31:0] load_data,
    output logic [31:0] wr_word,
    output logic        wr_en,
    output logic        err
);

    logic [1:0]  eff_lo;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        load_data = '0;
        wr_word   = mem_word;
        wr_en     = 1'b0;
        err       = !f3_legal(we, func3);
        eff_lo    = addr_lo;
`ifdef DMEM_MISALIGN_ERR_EN
        if ((func3[1:0] == 2'b01 && addr_lo[0]) ||
            (func3[1:0] == 2'b10 && addr_lo != 2'b00)) begin
            err = 1'b1;
        end
`else
        if (func3[1:0] == 2'b01) begin
            eff_lo[0] = 1'b0;
        end else if (func3[1:0] == 2'b10) begin
            eff_lo = 2'b00;
        end
`endif
        byte_sel = mem_word[{eff_lo, 3'b000} +: 8];
        half_sel = mem_word[{eff_lo[1], 4'b0000} +: 16];

        if (!err) begin
            if (we) begin
                wr_en = 1'b1;
                case (func3)
                    F3_SB:   wr_word[{eff_lo, 3'b000} +: 8]     = wdata[7:0];
                    F3_SH:   wr_word[{eff_lo[1], 4'b0000} +: 16] = wdata[15:0];
                    default: wr_word = wdata;
                endcase
            end else begin
                case (func3)
                    F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
                    F3_LBU:  load_data = {24'h0, byte_sel};
                    F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
                    F3_LHU:  load_data = {16'h0, half_sel};
                    default: load_data = mem_word;
                endcase
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store request at a time, waits
// WAIT_CYCLES, performs the access against a 2^DM_ADDRESS-byte word array and
// presents a registered response held until rsp_ready.
// Config macro: DMEM_MISALIGN_ERR_EN (see dmem_lane_align).
// Ports:
//   clk, reset              clock; synchronous active-low reset
//   req_valid/req_ready     request handshake
//   req_we, req_addr, req_wdata, req_func3   request payload
//   rsp_valid/rsp_ready     response handshake
//   rsp_rdata, rsp_err      load result / rejection flag
module dmem_responder
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_func3,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int         WORDS     = 2 ** (DM_ADDRESS - 2);
    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

    dmem_state_t state, next_state;
    logic [2:0]  wait_cnt;

    logic                  cap_we;
    logic [DM_ADDRESS-1:0] cap_addr;
    logic [DATA_W-1:0]     cap_wdata;
    logic [2:0]            cap_func3;

    logic [31:0] mem [WORDS];

    logic                  accept;
    logic                  enter_resp;
    logic                  op_we;
    logic [DM_ADDRESS-1:0] op_addr;
    logic [DATA_W-1:0]     op_wdata;
    logic [2:0]            op_func3;
    logic [31:0]           mem_word;
    logic [31:0]           load_data;
    logic [31:0]           wr_word;
    logic                  wr_en;
    logic                  lane_err;

    assign req_ready = (state == ST_IDLE) && reset;
    assign rsp_valid = (state == ST_RESP);
    assign accept    = req_valid && req_ready;

    // WAIT is left when the counter equals WAIT_CYCLES, so the response
    // appears WAIT_CYCLES+1 edges after the accept edge.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept) next_state = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (wait_cnt == WAIT_LAST) next_state = ST_RESP;
            ST_RESP: if (rsp_ready) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    assign enter_resp = (next_state == ST_RESP) && (state != ST_RESP);

    // With no wait states the access happens on the accept edge itself, before
    // the capture registers are loaded, so the live request is used then.
    always_comb begin
        if (state == ST_IDLE) begin
            op_we    = req_we;
            op_addr  = req_addr;
            op_wdata = req_wdata;
            op_func3 = req_func3;
        end else begin
            op_we    = cap_we;
            op_addr  = cap_addr;
            op_wdata = cap_wdata;
            op_func3 = cap_func3;
        end
    end

    assign mem_word = mem[op_addr[DM_ADDRESS-1:2]];

    dmem_lane_align u_lane (
        .we        (op_we),
        .func3     (op_func3),
        .addr_lo   (op_addr[1:0]),
        .wdata     (op_wdata),
        .mem_word  (mem_word),
        .load_data (load_data),
        .wr_word   (wr_word),
        .wr_en     (wr_en),
        .err       (lane_err)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + 3'd1;
            end
            if (enter_resp) begin
                rsp_rdata <= load_data;
                rsp_err   <= lane_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_we    <= req_we;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_func3 <= req_func3;
        end
    end

    // Array is never cleared; reset only blocks a pending write.
    always_ff @(posedge clk) begin
        if (reset && enter_resp && wr_en) begin
            mem[op_addr[DM_ADDRESS-1:2]] <= wr_word;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int W1 = 1;
    localparam int W3 = 3;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata, rsp_rdata;
    logic [2:0]  req_func3;

    logic        c_req_valid, c_req_ready, c_req_we, c_rsp_valid, c_rsp_ready, c_rsp_err;
    logic [8:0]  c_req_addr;
    logic [31:0] c_req_wdata, c_rsp_rdata;
    logic [2:0]  c_req_func3;

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl [512];

    always #5 clk = ~clk;

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(W1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_func3(req_func3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(W3)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(c_req_valid), .req_ready(c_req_ready), .req_we(c_req_we),
        .req_addr(c_req_addr), .req_wdata(c_req_wdata), .req_func3(c_req_func3),
        .rsp_valid(c_rsp_valid), .rsp_ready(c_rsp_ready),
        .rsp_rdata(c_rsp_rdata), .rsp_err(c_rsp_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Reference: byte-addressed array, access size 1<<func3[1:0].
    task automatic model_access(input logic we, input logic [8:0] addr, input logic [31:0] wdata,
                                input logic [2:0] f3, output logic [31:0] rd, output logic err);
        int size, a;
        logic legal;
        logic [31:0] v;
        rd = '0;
        err = 1'b0;
        legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 < 3'd6);
        if (!legal) begin
            err = 1'b1;
            return;
        end
        size = 1 << f3[1:0];
        a = int'(addr);
`ifdef DMEM_MISALIGN_ERR_EN
        if (a % size != 0) begin
            err = 1'b1;
            return;
        end
`else
        a = a - (a % size);
`endif
        if (we) begin
            for (int i = 0; i < size; i++) mdl[a + i] = wdata[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < size; i++) v = v | (32'(mdl[a + i]) << (8 * i));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
            rd = v;
        end
    endtask

    task automatic access(input logic we, input logic [8:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, input int hold,
                          input logic [31:0] exp_rd, input logic exp_err);
        int n, lat;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_func3 = f3;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) begin
            chk("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = 9'($urandom); req_wdata = $urandom; req_func3 = 3'($urandom);
        lat = 0;
        while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
        chk("latency", 32'(lat), 32'(1 + W1));
        if (!rsp_valid) return;
        chk("rdata", rsp_rdata, exp_rd);
        chk("err", 32'(rsp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, exp_rd);
            chk("hold_err", 32'(rsp_err), 32'(exp_err));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("released_valid", 32'(rsp_valid), 32'd0);
        chk("released_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic access3(input logic we, input logic [8:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3, input int hold,
                           input logic [31:0] exp_rd, input logic exp_err);
        int n, lat;
        @(negedge clk);
        c_req_valid = 1'b1; c_req_we = we; c_req_addr = addr; c_req_wdata = wdata; c_req_func3 = f3;
        n = 0;
        while (!c_req_ready && n < 20) begin @(negedge clk); n++; end
        if (!c_req_ready) begin
            chk("w3_accept_timeout", 32'(c_req_ready), 32'd1);
            c_req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        c_req_valid = 1'b0;
        c_req_addr = 9'($urandom); c_req_wdata = $urandom;
        lat = 0;
        while (!c_rsp_valid && lat < 20) begin @(negedge clk); lat++; end
        chk("w3_latency", 32'(lat), 32'(1 + W3));
        if (!c_rsp_valid) return;
        chk("w3_rdata", c_rsp_rdata, exp_rd);
        chk("w3_err", 32'(c_rsp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("w3_hold_valid", 32'(c_rsp_valid), 32'd1);
            chk("w3_hold_rdata", c_rsp_rdata, exp_rd);
            chk("w3_hold_err", 32'(c_rsp_err), 32'(exp_err));
            chk("w3_hold_req_ready", 32'(c_req_ready), 32'd0);
        end
        c_rsp_ready = 1'b1;
        @(negedge clk);
        c_rsp_ready = 1'b0;
        chk("w3_released_valid", 32'(c_rsp_valid), 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [22];

    initial begin
        logic [31:0] mr, w;
        logic        me, rwe;
        logic [2:0]  rf3;
        logic [8:0]  raddr;
        int          n;

        reset = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_func3 = '0; rsp_ready = 1'b0;
        c_req_valid = 1'b0; c_req_we = 1'b0; c_req_addr = '0; c_req_wdata = '0; c_req_func3 = '0; c_rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_w3_req_ready", 32'(c_req_ready), 32'd0);
        chk("reset_w3_rsp_valid", 32'(c_rsp_valid), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        // Known background: word i = C0DE_00ii.
        for (int i = 0; i < 128; i++) begin
            w = {16'hC0DE, 16'(i)};
            model_access(1'b1, 9'(i * 4), w, 3'b010, mr, me);
            access(1'b1, 9'(i * 4), w, 3'b010, 0, mr, me);
        end

        tbl[0]  = '{1'b1, 9'h010, 32'h12345678, 3'b010, 32'h00000000, 1'b0};
        tbl[1]  = '{1'b0, 9'h010, 32'h0,        3'b010, 32'h12345678, 1'b0};
        tbl[2]  = '{1'b1, 9'h013, 32'h000000AB, 3'b000, 32'h00000000, 1'b0};
        tbl[3]  = '{1'b0, 9'h013, 32'h0,        3'b000, 32'hFFFFFFAB, 1'b0};
        tbl[4]  = '{1'b0, 9'h013, 32'h0,        3'b100, 32'h000000AB, 1'b0};
        tbl[5]  = '{1'b0, 9'h010, 32'h0,        3'b010, 32'hAB345678, 1'b0};
        tbl[6]  = '{1'b0, 9'h012, 32'h0,        3'b001, 32'hFFFFAB34, 1'b0};
        tbl[7]  = '{1'b0, 9'h012, 32'h0,        3'b101, 32'h0000AB34, 1'b0};
`ifdef DMEM_MISALIGN_ERR_EN
        tbl[8]  = '{1'b0, 9'h011, 32'h0,        3'b001, 32'h00000000, 1'b1};
`else
        tbl[8]  = '{1'b0, 9'h011, 32'h0,        3'b001, 32'h00005678, 1'b0};
`endif
        tbl[9]  = '{1'b0, 9'h010, 32'h0,        3'b111, 32'h00000000, 1'b1};
        tbl[10] = '{1'b0, 9'h010, 32'h0,        3'b010, 32'hAB345678, 1'b0};
        tbl[11] = '{1'b1, 9'h010, 32'hFFFFFFFF, 3'b100, 32'h00000000, 1'b1};
        tbl[12] = '{1'b0, 9'h010, 32'h0,        3'b010, 32'hAB345678, 1'b0};
        tbl[13] = '{1'b1, 9'h016, 32'h0000BEEF, 3'b001, 32'h00000000, 1'b0};
        tbl[14] = '{1'b0, 9'h014, 32'h0,        3'b010, 32'hBEEF0005, 1'b0};
`ifdef DMEM_MISALIGN_ERR_EN
        tbl[15] = '{1'b1, 9'h01A, 32'h11223344, 3'b010, 32'h00000000, 1'b1};
        tbl[16] = '{1'b0, 9'h018, 32'h0,        3'b010, 32'hC0DE0006, 1'b0};
`else
        tbl[15] = '{1'b1, 9'h01A, 32'h11223344, 3'b010, 32'h00000000, 1'b0};
        tbl[16] = '{1'b0, 9'h018, 32'h0,        3'b010, 32'h11223344, 1'b0};
`endif
        tbl[17] = '{1'b0, 9'h017, 32'h0,        3'b000, 32'hFFFFFFBE, 1'b0};
        tbl[18] = '{1'b0, 9'h000, 32'h0,        3'b011, 32'h00000000, 1'b1};
        tbl[19] = '{1'b1, 9'h000, 32'hFFFFFFFF, 3'b011, 32'h00000000, 1'b1};
        tbl[20] = '{1'b0, 9'h000, 32'h0,        3'b010, 32'hC0DE0000, 1'b0};
`ifdef DMEM_MISALIGN_ERR_EN
        tbl[21] = '{1'b0, 9'h015, 32'h0,        3'b101, 32'h00000000, 1'b1};
`else
        tbl[21] = '{1'b0, 9'h015, 32'h0,        3'b101, 32'h00000005, 1'b0};
`endif

        for (int i = 0; i < 22; i++) begin
            model_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].f3, mr, me);
            access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].f3, i % 3, tbl[i].exp_rd, tbl[i].exp_err);
        end

        // Reset on the edge that would enter RESP: the store must be dropped.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h020; req_wdata = 32'hDEADBEEF; req_func3 = 3'b010;
        chk("abort_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_in_wait", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("abort_still_wait", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_req_ready_in_reset", 32'(req_ready), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_resp", 32'(rsp_valid), 32'd0);
        end
        chk("abort_ready_again", 32'(req_ready), 32'd1);
        access(1'b0, 9'h020, 32'h0, 3'b010, 1, 32'hC0DE0008, 1'b0);

        // Reset while a response is pending drops it.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 9'h004; req_func3 = 3'b010;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        chk("resp_before_reset", rsp_rdata, 32'hC0DE0001);
        reset = 1'b0;
        @(negedge clk);
        chk("resp_drop_valid", 32'(rsp_valid), 32'd0);
        chk("resp_drop_rdata", rsp_rdata, 32'd0);
        chk("resp_drop_err", 32'(rsp_err), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("resp_drop_ready", 32'(req_ready), 32'd1);

        // Randomised accesses against the byte-array model.
        for (int i = 0; i < 250; i++) begin
            rwe = 1'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                rf3 = rwe ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4));
                if (!rwe && rf3 == 3'd3) rf3 = 3'b101;
            end else begin
                rf3 = 3'($urandom);
            end
            raddr = 9'($urandom);
            w = $urandom;
            model_access(rwe, raddr, w, rf3, mr, me);
            access(rwe, raddr, w, rf3, $urandom_range(0, 2), mr, me);
        end

        // Three wait states, response held off for five cycles.
        access3(1'b1, 9'h000, 32'hCAFEF00D, 3'b010, 5, 32'h00000000, 1'b0);
        access3(1'b0, 9'h000, 32'h0,        3'b010, 5, 32'hCAFEF00D, 1'b0);
        access3(1'b0, 9'h002, 32'h0,        3'b001, 0, 32'hFFFFCAFE, 1'b0);
        access3(1'b1, 9'h001, 32'h00000055, 3'b000, 1, 32'h00000000, 1'b0);
        access3(1'b0, 9'h000, 32'h0,        3'b010, 0, 32'hCAFE550D, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
